// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: single-port RAM with wait states.
// Optional macro MEM_WRITE_ECHO_EN: completed in-range writes also load mem_data_out.
module mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] mar_in,
  input  logic [31:0] mdr_in,
  input  logic        read,
  input  logic        write,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [31:0]         r_addr;
  logic [31:0]         r_data;
  logic                r_wr;
  logic [31:0]         r_mem [DEPTH];

  logic                w_oor;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_we;

  assign w_oor = (r_addr[31:ADDR_W] != '0);
  assign w_idx = r_addr[ADDR_W-1:0];
  // clr gates the write so an abort landing on the ACCESS edge never commits
  assign w_we  = (r_state == S_ACCESS) && r_wr && !w_oor && !clr;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= r_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wr         <= 1'b0;
      mem_data_out <= '0;
      mem_ready    <= 1'b0;
      addr_err     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read || write) begin
            r_addr  <= mar_in;
            r_data  <= mdr_in;
            r_wr    <= write;
            r_cnt   <= CNT_LOAD;
            busy    <= 1'b1;
            r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!r_wr) begin
            mem_data_out <= w_oor ? 32'd0 : r_mem[w_idx];
          end
`ifdef MEM_WRITE_ECHO_EN
          else if (!w_oor) begin
            mem_data_out <= r_data;
          end
`endif
          mem_ready <= 1'b1;
          addr_err  <= w_oor;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: one instance with WAIT_CYCLES=1, one with 0.
module tb_mem_responder;

  logic        clk;
  logic        clr;
  logic [31:0] mar_in;
  logic [31:0] mdr_in;
  logic        read_a, write_a, read_b, write_b;
  logic [31:0] data1, data0;
  logic        ready1, ready0, busy1, busy0, err1, err0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [int];
  logic [31:0] last_out [2];

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .clr(clr), .mar_in(mar_in), .mdr_in(mdr_in),
    .read(read_a), .write(write_a),
    .mem_data_out(data1), .mem_ready(ready1), .busy(busy1), .addr_err(err1)
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clr(clr), .mar_in(mar_in), .mdr_in(mdr_in),
    .read(read_b), .write(write_b),
    .mem_data_out(data0), .mem_ready(ready0), .busy(busy0), .addr_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request on the selected instance; mar/mdr are disturbed after the
  // request edge so that only the latched values can produce the expected result.
  task automatic txn(input string tag, input int dut, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data);
    int   w      = (dut == 1) ? 1 : 0;
    int   key    = dut * 1024 + int'(addr[8:0]);
    logic in_rng = (addr[31:9] == 23'd0);
    int   n      = 0;
    int   bcnt   = 0;
    logic got    = 1'b0;
    exp_t e;
    exp_t act;

    if (wr) begin
      e.err = !in_rng;
      if (in_rng) model[key] = data;
`ifdef MEM_WRITE_ECHO_EN
      if (in_rng) last_out[dut] = data;
`endif
      e.data = last_out[dut];
    end else begin
      e.err  = !in_rng;
      e.data = in_rng ? (model.exists(key) ? model[key] : 32'hxxxx_xxxx) : 32'd0;
      last_out[dut] = e.data;
    end
    sb_q.push_back(e);

    @(negedge clk);
    mar_in = addr;
    mdr_in = data;
    if (dut == 1) begin read_a = rd; write_a = wr; end
    else          begin read_b = rd; write_b = wr; end
    @(posedge clk);
    #1;
    if (((dut == 1) ? busy1 : busy0) === 1'b1) bcnt++;
    @(negedge clk);
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    mar_in = addr ^ 32'h1;
    mdr_in = ~data;
    while (n < 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (((dut == 1) ? busy1 : busy0) === 1'b1) bcnt++;
      if (((dut == 1) ? ready1 : ready0) === 1'b1) got = 1'b1;
    end
    check({tag, " ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"}, 32'(n), 32'(w + 1));
      if (sb_q.size() > 0) begin
        act = sb_q.pop_front();
        check({tag, " data"}, (dut == 1) ? data1 : data0, act.data);
        check({tag, " addr_err"}, 32'((dut == 1) ? err1 : err0), 32'(act.err));
      end else begin
        check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end
      @(posedge clk);
      #1;
      if (((dut == 1) ? busy1 : busy0) === 1'b1) bcnt++;
      check({tag, " ready_pulse"}, 32'((dut == 1) ? ready1 : ready0), 32'd0);
      check({tag, " busy_cycles"}, 32'(bcnt), 32'(w + 2));
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    clr = 1'b0;
    mar_in = '0; mdr_in = '0;
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    last_out[0] = '0;
    last_out[1] = '0;
    #2 clr = 1'b1;
    #1;
    check("rst data1", data1, 32'd0);
    check("rst ready1", 32'(ready1), 32'd0);
    check("rst busy1", 32'(busy1), 32'd0);
    check("rst err1", 32'(err1), 32'd0);
    check("rst data0", data0, 32'd0);
    check("rst busy0", 32'(busy0), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    txn("w1_wr000", 1, 1'b0, 1'b1, 32'h0000_0000, 32'h6108_0005);
    txn("w1_rd000", 1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    txn("w1_wr031", 1, 1'b0, 1'b1, 32'h0000_0031, 32'h3131_3131);
    txn("w1_wr020", 1, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D);
    txn("w1_wr200", 1, 1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_0000);
    txn("w1_rd000b", 1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    txn("w1_rd200", 1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    txn("w1_rw010", 1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    txn("w1_rd010", 1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);

    // abort a write while it sits in WAIT
    @(negedge clk);
    mar_in = 32'h0000_0020; mdr_in = 32'h1234_5678; write_a = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy_before", 32'(busy1), 32'd1);
    @(negedge clk);
    write_a = 1'b0;
    clr = 1'b1;
    #1;
    check("abort busy1", 32'(busy1), 32'd0);
    check("abort data1", data1, 32'd0);
    check("abort data0", data0, 32'd0);
    last_out[0] = '0;
    last_out[1] = '0;
    @(negedge clk);
    clr = 1'b0;
    txn("w1_rd020", 1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);

    txn("w1_wr030", 1, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_ABCD);
    txn("w1_rd030", 1, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
    txn("w1_rd031", 1, 1'b1, 1'b0, 32'h0000_0031, 32'h0);

    txn("w0_wr005", 0, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_000C);
    txn("w0_rd005", 0, 1'b1, 1'b0, 32'h0000_0005, 32'h0);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
